// File: rtl/check422_pkg.sv
// Shared encodings and PRBS7 helpers for the RS-422 link-test transmitter.
// Defining CHECK422_PARITY_EN adds an even-parity slot after every word.
package check422_pkg;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_PRBS7 = 2'd2;
    localparam logic [1:0] MODE_WALK1 = 2'd3;

    typedef enum logic [1:0] {IDLE, ARM, SEND, FIN} state_e;

    // x^7 + x^6 + 1, output taken from the MSB
    localparam logic [6:0]  PRBS7_SEED  = 7'h7F;
    localparam int unsigned PRBS7_TAP_A = 6;
    localparam int unsigned PRBS7_TAP_B = 5;

`ifdef CHECK422_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
    endfunction

endpackage

// File: rtl/check422_bitclk_gen.sv
// Free-running bit clock divider: 50% duty registered clock plus a bit tick
// marking the phase where serial data is updated (falling edge of clk_out).
module check422_bitclk_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    output logic clk_out,
    output logic bit_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;

    // clk_out lags div_cnt by one clock so that it falls on the tick edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            clk_out <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
            clk_out <= (div_cnt >= CW'(DIV / 2));
        end
    end

    assign bit_tick = (div_cnt == '0);

endmodule

// File: rtl/check422_pattern_tx.sv
// RS-422 link-test burst transmitter: bit clock plus MSB-first test patterns.
// Build with CHECK422_PARITY_EN to append an even-parity bit after each word.
module check422_pattern_tx
    import check422_pkg::*;
#(
    parameter int unsigned       DIV    = 4,
    parameter int unsigned       WORD_W = 8,
    parameter logic [WORD_W-1:0] WORD   = WORD_W'(8'h3C),
    parameter int unsigned       CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burst_words,
    output logic             busy,
    output logic             done,
    output logic             clk_out,
    output logic             data_out
);

    localparam int unsigned       BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [WORD_W-1:0] WALK_INIT = {1'b1, {(WORD_W - 1){1'b0}}};

    logic bit_tick;

    check422_bitclk_gen #(
        .DIV(DIV)
    ) u_bitclk (
        .clk     (clk),
        .rstn    (rstn),
        .clk_out (clk_out),
        .bit_tick(bit_tick)
    );

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  words_left_q, words_left_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              par_slot_q, par_slot_d;
    logic              par_q, par_d;
    logic [6:0]        lfsr_q, lfsr_d;
    logic [WORD_W-1:0] inc_q, inc_d;
    logic [WORD_W-1:0] walk_q, walk_d;
    logic              data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] word_sel;
    logic              load_word;
    logic              shift_bit;
    logic              tx_bit;

    always_comb begin
        word_sel = WORD;
        case (mode_q)
            MODE_INC:   word_sel = inc_q;
            MODE_WALK1: word_sel = walk_q;
            default:    word_sel = WORD;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        words_left_d = words_left_q;
        sh_d         = sh_q;
        bit_cnt_d    = bit_cnt_q;
        par_slot_d   = par_slot_q;
        par_d        = par_q;
        lfsr_d       = lfsr_q;
        inc_d        = inc_q;
        walk_d       = walk_q;
        data_d       = data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_word    = 1'b0;
        shift_bit    = 1'b0;
        tx_bit       = 1'b0;

        case (state_q)
            IDLE: begin
                data_d = 1'b0;
                if (start) begin
                    mode_d       = mode;
                    words_left_d = burst_words;
                    busy_d       = 1'b1;
                    lfsr_d       = PRBS7_SEED;
                    inc_d        = '0;
                    walk_d       = WALK_INIT;
                    state_d      = (burst_words == '0) ? FIN : ARM;
                end
            end
            ARM: begin
                if (bit_tick) begin
                    load_word = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (bit_tick) begin
                    if (bit_cnt_q != '0) begin
                        shift_bit = 1'b1;
                    end else if (PARITY_EN && !par_slot_q) begin
                        data_d     = par_q;
                        par_slot_d = 1'b1;
                    end else if (words_left_q != '0) begin
                        load_word = 1'b1;
                    end else begin
                        data_d  = 1'b0;
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                data_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load_word) begin
            words_left_d = words_left_q - 1'b1;
            bit_cnt_d    = BIT_W'(WORD_W - 1);
            par_slot_d   = 1'b0;
            // PRBS bits come straight from the LFSR; other modes go through sh
            if (mode_q == MODE_PRBS7) begin
                tx_bit = lfsr_q[PRBS7_TAP_A];
                lfsr_d = prbs7_next(lfsr_q);
            end else begin
                tx_bit = word_sel[WORD_W-1];
                sh_d   = word_sel << 1;
            end
            if (mode_q == MODE_INC) begin
                inc_d = inc_q + 1'b1;
            end
            if (mode_q == MODE_WALK1) begin
                walk_d = {walk_q[0], walk_q[WORD_W-1:1]};
            end
            data_d = tx_bit;
            par_d  = tx_bit;
        end

        if (shift_bit) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            if (mode_q == MODE_PRBS7) begin
                tx_bit = lfsr_q[PRBS7_TAP_A];
                lfsr_d = prbs7_next(lfsr_q);
            end else begin
                tx_bit = sh_q[WORD_W-1];
                sh_d   = sh_q << 1;
            end
            data_d = tx_bit;
            par_d  = par_q ^ tx_bit;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            mode_q       <= MODE_FIXED;
            words_left_q <= '0;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            par_slot_q   <= 1'b0;
            par_q        <= 1'b0;
            lfsr_q       <= PRBS7_SEED;
            inc_q        <= '0;
            walk_q       <= WALK_INIT;
            data_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            words_left_q <= words_left_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            par_slot_q   <= par_slot_d;
            par_q        <= par_d;
            lfsr_q       <= lfsr_d;
            inc_q        <= inc_d;
            walk_q       <= walk_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_check422_pattern_tx.sv
// Self-checking bench for check422_pattern_tx (8-bit and 4-bit word instances).
module tb_check422_pattern_tx;

`ifdef CHECK422_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] burst_words = '0;
    logic        busy, done, clk_out, data_out;

    logic        start4 = 1'b0;
    logic [1:0]  mode4 = 2'd0;
    logic [7:0]  burst_words4 = '0;
    logic        busy4, done4, clk_out4, data_out4;

    always #5 clk = ~clk;

    check422_pattern_tx #(
        .DIV(4), .WORD_W(8), .WORD(8'h3C), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .burst_words(burst_words),
        .busy(busy), .done(done), .clk_out(clk_out), .data_out(data_out)
    );

    check422_pattern_tx #(
        .DIV(4), .WORD_W(4), .WORD(4'hA), .CNT_W(8)
    ) u_dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .mode(mode4), .burst_words(burst_words4),
        .busy(busy4), .done(done4), .clk_out(clk_out4), .data_out(data_out4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Scoreboards of expected serial bits, filled before each start.
    bit q[$];
    bit q4[$];
    bit prbs_ref[0:127];

    task automatic push_word(input logic [7:0] w, input int width, input bit to4);
        bit p = 1'b0;
        for (int i = width - 1; i >= 0; i--) begin
            p ^= w[i];
            if (to4) q4.push_back(w[i]); else q.push_back(w[i]);
        end
        if (PB == 1) begin
            if (to4) q4.push_back(p); else q.push_back(p);
        end
    endtask

    // Main-instance monitor: bits sampled on clk_out rise, once the first tick is seen.
    bit armed = 0, prev_clk = 0, prev_busy = 0;
    int done_cnt = 0, t_arm = 0, t_done = 0, t_busy = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                armed = 0; prev_clk = 0; prev_busy = 0;
            end else begin
                if (done) begin done_cnt++; t_done = cyc; end
                if (busy && !prev_busy) t_busy = cyc;
                if (!busy) begin
                    armed = 0;
                    chk("idle_data", {31'd0, data_out}, 32'd0);
                end else if (!armed && prev_busy && prev_clk && !clk_out) begin
                    armed = 1; t_arm = cyc;
                end
                if (armed && !prev_clk && clk_out) begin
                    chk("bit_avail", {31'd0, q.size() > 0}, 32'd1);
                    if (q.size() > 0) chk("data_bit", {31'd0, data_out}, {31'd0, q.pop_front()});
                end
                prev_clk = clk_out; prev_busy = busy;
            end
        end
    end

    bit armed4 = 0, prev_clk4 = 0, prev_busy4 = 0;
    int done_cnt4 = 0, t_arm4 = 0, t_done4 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                armed4 = 0; prev_clk4 = 0; prev_busy4 = 0;
            end else begin
                if (done4) begin done_cnt4++; t_done4 = cyc; end
                if (!busy4) armed4 = 0;
                else if (!armed4 && prev_busy4 && prev_clk4 && !clk_out4) begin
                    armed4 = 1; t_arm4 = cyc;
                end
                if (armed4 && !prev_clk4 && clk_out4) begin
                    chk("bit4_avail", {31'd0, q4.size() > 0}, 32'd1);
                    if (q4.size() > 0) chk("data4_bit", {31'd0, data_out4}, {31'd0, q4.pop_front()});
                end
                prev_clk4 = clk_out4; prev_busy4 = busy4;
            end
        end
    end

    task automatic run_burst(input logic [1:0] m, input int n, input bit poke);
        int dc0 = done_cnt;
        @(negedge clk);
        mode = m; burst_words = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20000 && done_cnt == dc0; i++) begin
            @(negedge clk);
            if (poke && i == 60) begin
                start = 1'b1; mode = 2'd1; burst_words = 16'd7;
            end else begin
                start = 1'b0;
            end
        end
        chk("done_seen", {31'd0, done_cnt != dc0}, 32'd1);
        repeat (6) @(negedge clk);
        chk("done_once", 32'(done_cnt - dc0), 32'd1);
        chk("queue_empty", 32'(q.size()), 32'd0);
        if (n == 0) chk("zero_len_done", 32'(t_done - t_busy), 32'd1);
        else chk("burst_len", 32'(t_done - t_arm), 32'(n * (8 + PB) * DIV + 1));
    endtask

    initial begin
        logic [7:0] pat = '0;
        int dc0;
        int bi = 0;

        for (int i = 0; i < 128; i++) prbs_ref[i] = (i < 7) ? 1'b1 : prbs_ref[i-7] ^ prbs_ref[i-6];

        #1;
        chk("rst_outs", {28'd0, clk_out, data_out, busy, done}, 32'd0);
        chk("rst_outs4", {28'd0, clk_out4, data_out4, busy4, done4}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat = {pat[6:0], clk_out};
        end
        chk("clk_out_wave", {24'd0, pat}, 32'h33);

        // Fixed word, two words.
        push_word(8'h3C, 8, 0); push_word(8'h3C, 8, 0);
        run_burst(2'd0, 2, 0);

        // Incrementing words.
        for (int w = 0; w < 3; w++) push_word(8'(w), 8, 0);
        run_burst(2'd1, 3, 0);

        // PRBS7 over 128 bits; parity taken per 8-bit group.
        for (int w = 0; w < 16; w++) begin
            bit p = 1'b0;
            for (int b = 0; b < 8; b++) begin
                q.push_back(prbs_ref[bi]); p ^= prbs_ref[bi]; bi++;
            end
            if (PB == 1) q.push_back(p);
        end
        run_burst(2'd2, 16, 0);

        // Walking one with a start pulse and input changes mid-burst.
        for (int w = 0; w < 9; w++) push_word(8'h80 >> (w % 8), 8, 0);
        run_burst(2'd3, 9, 1);

        // Zero-length burst: no bits, done one clock after FIN.
        run_burst(2'd0, 0, 0);

`ifdef CHECK422_PARITY_EN
        push_word(8'h3C, 8, 0);
        run_burst(2'd0, 1, 0);
`endif

        // 4-bit incrementing counter wraps after 16 words.
        for (int w = 0; w < 17; w++) push_word(8'(w % 16), 4, 1);
        dc0 = done_cnt4;
        @(negedge clk);
        mode4 = 2'd1; burst_words4 = 8'd17; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 20000 && done_cnt4 == dc0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("done4_once", 32'(done_cnt4 - dc0), 32'd1);
        chk("queue4_empty", 32'(q4.size()), 32'd0);
        chk("burst4_len", 32'(t_done4 - t_arm4), 32'(17 * (4 + PB) * DIV + 1));

        // Reset in the middle of a burst.
        dc0 = done_cnt;
        push_word(8'h3C, 8, 0); push_word(8'h3C, 8, 0); push_word(8'h3C, 8, 0);
        @(negedge clk);
        mode = 2'd0; burst_words = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async", {29'd0, data_out, busy, clk_out}, 32'd0);
        q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt - dc0), 32'd0);
        chk("idle_after_rst", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
